array_allocator: RTL and testbench

Shared allocator for the heap array slots used by the test-program machine. Arbitrates alloc/free requests from up to `NReq` requesters, round-robin. Hands out array indices from a LIFO freed-array stack, falling back to a high-water `allocs` counter. Zeroes the allocated array's size entry through a write port into the external `arraySizes` memory.

---
 rtl/array_allocator_pkg.sv | 23 ++
 rtl/array_allocator_rr_arbiter.sv | 42 ++++
 rtl/array_allocator.sv | 243 ++++++++++++++++++++++++
 tb/tb_array_allocator.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_allocator_pkg.sv
// Shared definitions for the heap array allocator: default widths, FSM state
// encoding, request op encoding and a small index-width helper.
package array_allocator_pkg;

  localparam int DEF_MEM_ELEM_WIDTH = 12;
  localparam int DEF_N_ARRAYS       = 200;
  localparam int DEF_N_REQ          = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } alloc_state_e;

  localparam logic OP_ALLOC = 1'b0;
  localparam logic OP_FREE  = 1'b1;

  // Bits needed to index n items, never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/array_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above
// the pointer, wrapping around. The pointer register lives in the parent.
module rr_arbiter
  import array_allocator_pkg::*;
#(
  parameter int NReq = DEF_N_REQ,
  localparam int PW  = idx_width(NReq)
) (
  input  logic [NReq-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NReq-1:0] o_grant,
  output logic [PW-1:0]   o_winner,
  output logic            o_any
);

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_pos;

  // Scan from the pointer upward and keep the first pending requester.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_grant  = '0;
    o_winner = '0;
    o_any    = 1'b0;
    w_sum    = '0;
    w_pos    = '0;
    for (int off = 0; off < NReq; off++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(off);
      if (w_sum >= (PW+1)'(NReq)) begin
        w_sum = w_sum - (PW+1)'(NReq);
      end
      w_pos = w_sum[PW-1:0];
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_winner       = w_pos;
      end
    end
  end

endmodule

// File: rtl/array_allocator.sv
// Shared heap-array allocator. Grants one alloc/free request at a time
// (round-robin), hands out indices from a LIFO freed stack or a high-water
// counter, and zeroes the new array's size entry in the external arraySizes
// memory. Optional feature macro: ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN keeps
// a per-index live bitmap and rejects frees of indices that are not live.
module array_allocator
  import array_allocator_pkg::*;
#(
  parameter int MemoryElementWidth = DEF_MEM_ELEM_WIDTH,
  parameter int NArrays            = DEF_N_ARRAYS,
  parameter int NReq               = DEF_N_REQ
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NReq-1:0]                    req_valid,
  input  logic [NReq-1:0]                    req_free,
  input  logic [NReq*MemoryElementWidth-1:0] req_array,
  output logic [NReq-1:0]                    req_ready,
  output logic [NReq-1:0]                    rsp_valid,
  output logic [MemoryElementWidth-1:0]      rsp_array,
  output logic                               rsp_error,
  output logic                               size_we,
  output logic [MemoryElementWidth-1:0]      size_addr,
  output logic [MemoryElementWidth-1:0]      size_data,
  output logic [MemoryElementWidth-1:0]      allocs,
  output logic [MemoryElementWidth-1:0]      in_use
);

  localparam int MW = MemoryElementWidth;
  localparam int PW = idx_width(NReq);
  localparam int AW = idx_width(NArrays);
  localparam int SW = $clog2(NArrays + 1);
  localparam logic [MW-1:0] LP_N_ARRAYS = MW'(NArrays);

  alloc_state_e    r_state;
  alloc_state_e    w_next_state;

  // Arbitration and the latched transaction.
  logic [NReq-1:0] w_grant;
  logic [PW-1:0]   w_winner;
  logic            w_any;
  logic            w_accept;
  logic            w_req_op;
  logic [MW-1:0]   w_req_index;
  logic [PW-1:0]   r_rr;
  logic [NReq-1:0] r_grant;
  logic            r_op;
  logic [MW-1:0]   r_index;

  // Allocation bookkeeping. The stack holds at most NArrays entries because
  // stack depth plus in_use always equals allocs, which never exceeds NArrays.
  logic [MW-1:0]   r_allocs;
  logic [MW-1:0]   r_in_use;
  logic [SW-1:0]   r_sp;
  logic [MW-1:0]   r_stack [NArrays];
  logic [MW-1:0]   w_stack_top;

  // Decision taken in SERVE.
  logic            w_serve;
  logic            w_pop;
  logic            w_push;
  logic            w_bump;
  logic            w_ok;
  logic [MW-1:0]   w_result;
  logic            w_free_tracked;
  logic            w_size_we;

  // Response registers.
  logic [NReq-1:0] r_rsp_valid;
  logic [MW-1:0]   r_rsp_array;
  logic            r_rsp_error;

  rr_arbiter #(
    .NReq (NReq)
  ) u_rr_arbiter (
    .i_req    (req_valid),
    .i_ptr    (r_rr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_accept    = (r_state == IDLE) && w_any;
  assign w_serve     = (r_state == SERVE);
  assign w_req_op    = req_free[w_winner];
  assign w_stack_top = r_stack[AW'(r_sp - 1'b1)];

  // Pick the winning requester's index slice.
  always_comb begin
    w_req_index = '0;
    for (int k = 0; k < NReq; k++) begin
      if (w_winner == PW'(k)) begin
        w_req_index = req_array[k*MW +: MW];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: a granted request walks IDLE -> SERVE -> RESP -> IDLE.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next_state = SERVE;
      SERVE:   w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: accept pulse in IDLE, size write strobe in SERVE.
  always_comb begin
    req_ready = (r_state == IDLE) ? w_grant : '0;
    w_size_we = w_serve && (r_op == OP_ALLOC) && w_ok;
    size_addr = w_size_we ? w_result : '0;
  end

  assign size_we   = w_size_we;
  assign size_data = '0;

`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
  logic [NArrays-1:0] r_live_map;

  // Live bitmap: set on a successful alloc, cleared on an accepted free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_live_map <= '0;
    end else if (w_serve) begin
      if ((r_op == OP_ALLOC) && w_ok) begin
        r_live_map[AW'(w_result)] <= 1'b1;
      end else if (w_push) begin
        r_live_map[AW'(r_index)] <= 1'b0;
      end
    end
  end

  // Out-of-range reads are masked by the index range check in SERVE.
  assign w_free_tracked = r_live_map[AW'(r_index)] && (r_index < r_allocs);
`else
  assign w_free_tracked = 1'b1;
`endif

  // SERVE decision: alloc pops the stack, then falls back to the counter;
  // free pushes when the index is in range and something is in use.
  always_comb begin
    w_pop    = 1'b0;
    w_push   = 1'b0;
    w_bump   = 1'b0;
    w_ok     = 1'b0;
    w_result = r_index;
    if (r_op == OP_ALLOC) begin
      w_result = '0;
      if (r_sp != '0) begin
        w_pop    = 1'b1;
        w_ok     = 1'b1;
        w_result = w_stack_top;
      end else if (r_allocs < LP_N_ARRAYS) begin
        w_bump   = 1'b1;
        w_ok     = 1'b1;
        w_result = r_allocs;
      end
    end else if ((r_index < LP_N_ARRAYS) && (r_in_use != '0) && w_free_tracked) begin
      w_push = 1'b1;
      w_ok   = 1'b1;
    end
  end

  // Latch the granted request and advance the round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr    <= '0;
      r_grant <= '0;
      r_op    <= OP_ALLOC;
      r_index <= '0;
    end else if (w_accept) begin
      r_grant <= w_grant;
      r_op    <= w_req_op;
      r_index <= w_req_index;
      r_rr    <= (w_winner == PW'(NReq - 1)) ? '0 : w_winner + 1'b1;
    end
  end

  // Counters and stack pointer move only at the end of SERVE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_allocs <= '0;
      r_in_use <= '0;
      r_sp     <= '0;
    end else if (w_serve) begin
      if (w_bump) begin
        r_allocs <= r_allocs + 1'b1;
      end
      if (w_pop) begin
        r_sp <= r_sp - 1'b1;
      end else if (w_push) begin
        r_sp <= r_sp + 1'b1;
      end
      if (w_push) begin
        r_in_use <= r_in_use - 1'b1;
      end else if (w_ok) begin
        r_in_use <= r_in_use + 1'b1;
      end
    end
  end

  // Freed-index stack storage.
  always_ff @(posedge clock) begin
    // NOTE: storage arrays are not reset; r_sp alone defines which entries are valid.
    if (w_serve && w_push) begin
      r_stack[AW'(r_sp)] <= r_index;
    end
  end

  // Registered response, presented during RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= '0;
      r_rsp_array <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_valid <= w_serve ? r_grant : '0;
      if (w_serve) begin
        r_rsp_array <= w_result;
        r_rsp_error <= !w_ok;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_array = r_rsp_array;
  assign rsp_error = r_rsp_error;
  assign allocs    = r_allocs;
  assign in_use    = r_in_use;

endmodule

// File: tb/tb_array_allocator.sv
// Self-checking bench for array_allocator (NArrays=4, NReq=4): directed
// scenarios followed by random multi-requester traffic, every cycle compared
// against a transaction-level reference model built on a queue of freed
// indices and plain integer counters.
module tb_array_allocator;

  localparam int MEW = 12;
  localparam int NA  = 4;
  localparam int NR  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_free = '0;
  logic [NR*MEW-1:0] req_array = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [MEW-1:0]    rsp_array;
  logic              rsp_error;
  logic              size_we;
  logic [MEW-1:0]    size_addr;
  logic [MEW-1:0]    size_data;
  logic [MEW-1:0]    allocs;
  logic [MEW-1:0]    in_use;

  always #5 clock = ~clock;

  array_allocator #(
    .MemoryElementWidth (MEW),
    .NArrays            (NA),
    .NReq               (NR)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_free  (req_free),
    .req_array (req_array),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_array (rsp_array),
    .rsp_error (rsp_error),
    .size_we   (size_we),
    .size_addr (size_addr),
    .size_data (size_data),
    .allocs    (allocs),
    .in_use    (in_use)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Requester-side drive state, applied just after each rising edge.
  bit d_valid [NR];
  bit d_free  [NR];
  int d_idx   [NR];

  // Reference model.
  int m_free_q[$];
  int m_allocs, m_in_use, m_rr;
  int v_allocs, v_in_use;
  bit m_live [NA];
  int m_phase;
  int m_win, m_idx;
  bit m_free_op, m_err, m_we;

  // Observed responses, for the directed scenario checks.
  int obs_idx[$];
  int obs_err[$];
  int obs_win[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_drive();
    for (int k = 0; k < NR; k++) begin
      req_valid[k] = d_valid[k];
      req_free[k]  = d_free[k];
      req_array[k*MEW +: MEW] = MEW'(d_idx[k]);
    end
  endtask

  task automatic post(input int k, input bit free_op, input int idx);
    d_valid[k] = 1'b1;
    d_free[k]  = free_op;
    d_idx[k]   = idx;
  endtask

  task automatic model_reset();
    m_free_q.delete();
    m_allocs = 0; m_in_use = 0; m_rr = 0;
    v_allocs = 0; v_in_use = 0;
    m_phase  = 0;
    for (int i = 0; i < NA; i++) m_live[i] = 1'b0;
  endtask

  function automatic int model_winner();
    for (int off = 0; off < NR; off++) begin
      if (d_valid[(m_rr + off) % NR]) return (m_rr + off) % NR;
    end
    return -1;
  endfunction

  // Whole-transaction outcome, decided from the rules at grant time.
  task automatic model_accept(input int k);
    bit ok;
    m_win = k; m_free_op = d_free[k]; m_idx = d_idx[k];
    m_we = 1'b0; m_err = 1'b0;
    if (!m_free_op) begin
      if (m_free_q.size() > 0) begin
        m_idx = m_free_q.pop_back();
        m_we = 1'b1; m_in_use++; m_live[m_idx] = 1'b1;
      end else if (m_allocs < NA) begin
        m_idx = m_allocs;
        m_allocs++; m_we = 1'b1; m_in_use++; m_live[m_idx] = 1'b1;
      end else begin
        m_err = 1'b1; m_idx = 0;
      end
    end else begin
      ok = (m_idx < NA) && (m_in_use > 0);
`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
      if (ok) ok = m_live[m_idx] && (m_idx < m_allocs);
`endif
      if (ok) begin
        m_free_q.push_back(m_idx);
        m_in_use--; m_live[m_idx] = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  // One clock: drive after the edge, compare everything at the falling edge.
  task automatic step();
    logic [NR-1:0] exp_ready;
    logic [NR-1:0] exp_rsp;
    int w;
    @(posedge clock);
    #1;
    apply_drive();
    @(negedge clock);
    exp_ready = '0;
    exp_rsp   = '0;
    w = -1;
    if (m_phase == 0) begin
      w = model_winner();
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("size_we", 32'(size_we), 32'((m_phase == 1) && m_we));
    check("size_addr", 32'(size_addr), (m_phase == 1 && m_we) ? m_idx : 0);
    check("size_data", 32'(size_data), 0);
    if (m_phase == 2) begin
      v_allocs = m_allocs;
      v_in_use = m_in_use;
      exp_rsp[m_win] = 1'b1;
    end
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (m_phase == 2) begin
      check("rsp_array", 32'(rsp_array), m_idx);
      check("rsp_error", 32'(rsp_error), 32'(m_err));
      obs_idx.push_back(int'(rsp_array));
      obs_err.push_back(int'(rsp_error));
      for (int k = 0; k < NR; k++) if (rsp_valid[k]) obs_win.push_back(k);
    end
    check("allocs", 32'(allocs), v_allocs);
    check("in_use", 32'(in_use), v_in_use);
    case (m_phase)
      0: if (w >= 0) begin
        model_accept(w);
        m_rr = (w + 1) % NR;
        d_valid[w] = 1'b0;
        m_phase = 1;
      end
      1: m_phase = 2;
      default: m_phase = 0;
    endcase
  endtask

  function automatic bit any_pending();
    for (int k = 0; k < NR; k++) if (d_valid[k]) return 1'b1;
    return 1'b0;
  endfunction

  // Run until every request has completed, within a cycle budget.
  task automatic drain(input int budget);
    int c = 0;
    while ((any_pending() || m_phase != 0) && c < budget) begin
      step();
      c++;
    end
    check("drain_in_budget", 32'(c < budget), 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < NR; k++) begin
      d_valid[k] = 1'b0; d_free[k] = 1'b0; d_idx[k] = 0;
    end
    apply_drive();
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_array", 32'(rsp_array), 0);
    check("rst_rsp_error", 32'(rsp_error), 0);
    check("rst_size_we", 32'(size_we), 0);
    check("rst_size_addr", 32'(size_addr), 0);
    check("rst_allocs", 32'(allocs), 0);
    check("rst_in_use", 32'(in_use), 0);
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < NR; k++) begin
      d_valid[k] = 1'b0; d_free[k] = 1'b0; d_idx[k] = 0;
    end

    // Three allocs from requester 0 come from the counter: 0, 1, 2.
    do_reset();
    repeat (3) begin
      post(0, 1'b0, 0);
      drain(20);
    end
    check("first_alloc_0", 32'(obs_idx[obs_idx.size()-3]), 0);
    check("first_alloc_1", 32'(obs_idx[obs_idx.size()-2]), 1);
    check("first_alloc_2", 32'(obs_idx[obs_idx.size()-1]), 2);
    check("allocs_after_3", 32'(allocs), 3);

    // Free 1 then 2; allocs come back LIFO: 2, then 1.
    post(0, 1'b1, 1); drain(20);
    post(0, 1'b1, 2); drain(20);
    post(0, 1'b0, 0); drain(20);
    check("lifo_first", 32'(obs_idx[obs_idx.size()-1]), 2);
    post(0, 1'b0, 0); drain(20);
    check("lifo_second", 32'(obs_idx[obs_idx.size()-1]), 1);
    check("allocs_stays_3", 32'(allocs), 3);

    // Four simultaneous allocs are granted in order 0..3.
    do_reset();
    obs_win.delete();
    obs_idx.delete();
    for (int k = 0; k < NR; k++) post(k, 1'b0, 0);
    drain(40);
    for (int k = 0; k < NR; k++) begin
      check("rr_order", 32'(obs_win[k]), k);
      check("rr_index", 32'(obs_idx[k]), k);
    end

    // Exhausted: fifth alloc errors with index 0; out-of-range free errors.
    post(2, 1'b0, 0); drain(20);
    check("exhaust_err", 32'(obs_err[obs_err.size()-1]), 1);
    check("exhaust_idx", 32'(obs_idx[obs_idx.size()-1]), 0);
    post(1, 1'b1, 9); drain(20);
    check("free9_err", 32'(obs_err[obs_err.size()-1]), 1);
    check("free9_idx", 32'(obs_idx[obs_idx.size()-1]), 9);
    check("free9_in_use", 32'(in_use), 4);

    // Double free of index 0 is rejected either way.
    do_reset();
    post(0, 1'b0, 0); drain(20);
    post(0, 1'b1, 0); drain(20);
    check("free_ok", 32'(obs_err[obs_err.size()-1]), 0);
    post(0, 1'b1, 0); drain(20);
    check("double_free_err", 32'(obs_err[obs_err.size()-1]), 1);
    check("double_free_in_use", 32'(in_use), 0);

    // Reset during SERVE aborts the alloc: no response, counters cleared.
    post(3, 1'b0, 0);
    step();
    do_reset();
    repeat (4) step();
    post(0, 1'b0, 0); drain(20);
    check("post_abort_idx", 32'(obs_idx[obs_idx.size()-1]), 0);
    check("post_abort_allocs", 32'(allocs), 1);

    // Random traffic, including withdrawn requests and illegal frees.
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < NR; k++) begin
        if (!d_valid[k]) begin
          if ($urandom_range(0, 3) == 0) post(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, NA + 2)));
        end else if ($urandom_range(0, 19) == 0) begin
          d_valid[k] = 1'b0;
        end
      end
      step();
    end
    drain(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
